man_game_ctrl: RTL

//   Top-level game sequencer for the jump game. Produces the 3-bit state code that gates
//   the man's velocity-charge counter (charge in ACCU, clear on jump completion in JUMP).

---
 rtl/man_game_pkg.sv | 34 +++
 rtl/man_game_ctrl_debounce.sv | 67 ++++++
 rtl/man_game_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/man_game_pkg.sv
// man_game_pkg: shared state codes for the jump-game sequencer.
// Every block that decodes o_state imports these names so the numeric
// codes live in exactly one place.
package man_game_pkg;

    // Raw 3-bit state codes as seen on o_state by the velocity, platform and
    // landing blocks.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] GEN  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] ACCU = 3'd3;
    localparam logic [2:0] JUMP = 3'd4;
    localparam logic [2:0] LAND = 3'd5;
    localparam logic [2:0] OVER = 3'd6;

    // Enumerated view of the same codes for the sequencer FSM. Code 7 is
    // deliberately left unnamed: it is illegal and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = IDLE,
        ST_GEN  = GEN,
        ST_WAIT = WAIT,
        ST_ACCU = ACCU,
        ST_JUMP = JUMP,
        ST_LAND = LAND,
        ST_OVER = OVER
    } state_e;

    // States in which a debounced press or release has any effect. In GEN,
    // JUMP and LAND the button is ignored.
    function automatic logic btn_listens(input logic [2:0] s);
        btn_listens = (s == IDLE) || (s == WAIT) || (s == ACCU) || (s == OVER);
    endfunction

endpackage

// File: rtl/man_game_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter for the player
// button. o_level follows the synchronised input once it has differed from
// the current level for DEBOUNCE_CYC consecutive samples, so the total
// latency from i_raw to o_level is DEBOUNCE_CYC + 2 cycles. o_rise/o_fall
// are single-cycle strobes that coincide with the first cycle of the new
// level.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk_machine,
    input  logic rst_machine,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Count consecutive samples that disagree with the current level; any
    // agreeing sample restarts the count, so glitches never accumulate.
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync1;
                r_rise  <= r_sync1;
                r_fall  <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/man_game_ctrl.sv
// man_game_ctrl: top-level sequencer of the jump game.
// Debounces the player button, steps through
// IDLE -> GEN -> WAIT -> ACCU -> JUMP -> LAND -> (GEN | OVER), issues the
// platform request and launch pulses, and keeps current / best scores.
//
// Handshakes: i_gen_done, i_jump_done and i_land_valid are single-cycle
// pulses that are acted on only in GEN, JUMP and LAND respectively; a pulse
// in any other state is dropped, never remembered. o_gen_req fires in the
// first GEN cycle, o_jump_start in the first JUMP cycle; both are registered
// and they can never coincide because they mark entry into different states.
//
// Optional feature, macro MAN_ACCU_TIMEOUT_EN: a dwell counter forces
// ACCU -> JUMP after ACCU_MAX_CYC cycles of charging even while the button
// is still held. Without the macro ACCU is left only on a release.
module man_game_ctrl
    import man_game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int ACCU_MAX_CYC = 16777215,
    parameter int SCORE_W      = 8
) (
    input  logic               clk_machine,
    input  logic               rst_machine,
    input  logic               i_btn_raw,
    input  logic               i_gen_done,
    input  logic               i_jump_done,
    input  logic               i_land_valid,
    input  logic               i_land_ok,
    output logic [2:0]         o_state,
    output logic               o_btn_db,
    output logic               o_gen_req,
    output logic               o_jump_start,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_best
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    logic               w_db_level;
    logic               w_db_rise;
    logic               w_db_fall;
    logic               w_press;
    logic               w_release;
    logic               w_timeout;

    state_e             r_state;
    logic               r_gen_req;
    logic               r_jump_start;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_best;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk_machine  (clk_machine),
        .rst_machine  (rst_machine),
        .i_raw        (i_btn_raw),
        .o_level      (w_db_level),
        .o_rise       (w_db_rise),
        .o_fall       (w_db_fall)
    );

    // Edge strobes are masked in states that ignore the button, so a press
    // made during GEN/JUMP/LAND can never leak into a later state.
    assign w_press   = w_db_rise & btn_listens(r_state);
    assign w_release = w_db_fall & btn_listens(r_state);

`ifdef MAN_ACCU_TIMEOUT_EN
    localparam int DW_W = $clog2(ACCU_MAX_CYC + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(ACCU_MAX_CYC - 1);

    logic [DW_W-1:0] r_dwell;

    // Dwell counter: held at zero outside ACCU, so it starts from zero on
    // every ACCU entry and counts the cycles spent charging.
    always_ff @(posedge clk_machine) begin
        if (rst_machine || (r_state != ST_ACCU)) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_ACCU) && (r_dwell == DWELL_LAST);
`else
    assign w_timeout = 1'b0;

    // ACCU_MAX_CYC only matters with the dwell counter; this empty block
    // just keeps the parameter referenced in this build.
    if (ACCU_MAX_CYC < 1) begin : g_accu_max_ignored
    end
`endif

    // Sequencer FSM with registered state code, pulses and score registers.
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            r_state      <= ST_IDLE;
            r_gen_req    <= 1'b0;
            r_jump_start <= 1'b0;
            r_score      <= '0;
            r_best       <= '0;
        end else begin
            r_gen_req    <= 1'b0;
            r_jump_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state   <= ST_GEN;
                        r_gen_req <= 1'b1;
                        r_score   <= '0;
                    end
                end
                ST_GEN: begin
                    // Accepted even in the same cycle as o_gen_req.
                    if (i_gen_done) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Only a fresh press counts; a button still held from an
                    // earlier state produces no rising strobe here.
                    if (w_press) begin
                        r_state <= ST_ACCU;
                    end
                end
                ST_ACCU: begin
                    if (w_release || w_timeout) begin
                        r_state      <= ST_JUMP;
                        r_jump_start <= 1'b1;
                    end
                end
                ST_JUMP: begin
                    if (i_jump_done) begin
                        r_state <= ST_LAND;
                    end
                end
                ST_LAND: begin
                    if (i_land_valid) begin
                        if (i_land_ok) begin
                            if (r_score != SCORE_MAX) begin
                                r_score <= r_score + 1'b1;
                            end
                            r_state   <= ST_GEN;
                            r_gen_req <= 1'b1;
                        end else begin
                            if (r_score > r_best) begin
                                r_best <= r_score;
                            end
                            r_state <= ST_OVER;
                        end
                    end
                end
                ST_OVER: begin
                    if (w_press) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    // Illegal code 7: recover silently, no pulses.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_btn_db     = w_db_level;
    assign o_gen_req    = r_gen_req;
    assign o_jump_start = r_jump_start;
    assign o_score      = r_score;
    assign o_best       = r_best;

endmodule
